// File: rtl/cnn_window_gen_pkg.sv
// ---------------------------------------------------------------------------
// cnn_window_gen_pkg
// Purpose : shared defaults and helpers for the convolution window generator.
//           The defaults are the core geometry: channel count, kernel size,
//           feature-map bit width and image size.
// Contents: *_DEF localparams, cnt_width() helper.
// ---------------------------------------------------------------------------
package cnn_window_gen_pkg;

  localparam int CI_DEF     = 1;   // channels per pixel beat
  localparam int KX_DEF     = 3;   // kernel width
  localparam int KY_DEF     = 3;   // kernel height
  localparam int I_F_BW_DEF = 8;   // feature-map element width
  localparam int IW_DEF     = 28;  // image width  (must be >= KX)
  localparam int IH_DEF     = 28;  // image height (must be >= KY)

  // Counter width for a 0..n-1 counter. Never returns less than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_window_gen_if.sv
// ---------------------------------------------------------------------------
// cnn_window_gen_if
// Purpose : pixel-in / window-out bus of cnn_window_gen.
// Signals : i_in_valid, i_in_pixel      - raster-order pixel beat (no ready)
//           o_ot_valid, o_ot_fmap       - one-cycle window pulse + window data
//           o_ot_frame_done             - marks the last window of a frame
// Modports: master = pixel source / window sink, slave = window generator.
// ---------------------------------------------------------------------------
interface cnn_window_gen_if
  import cnn_window_gen_pkg::*;
#(
  parameter int CI     = CI_DEF,
  parameter int KX     = KX_DEF,
  parameter int KY     = KY_DEF,
  parameter int I_F_BW = I_F_BW_DEF
) ();

  logic                          i_in_valid;
  logic [CI*I_F_BW-1:0]          i_in_pixel;
  logic                          o_ot_valid;
  logic [CI*KX*KY*I_F_BW-1:0]    o_ot_fmap;
  logic                          o_ot_frame_done;

  modport master (
    output i_in_valid, i_in_pixel,
    input  o_ot_valid, o_ot_fmap, o_ot_frame_done
  );

  modport slave (
    input  i_in_valid, i_in_pixel,
    output o_ot_valid, o_ot_fmap, o_ot_frame_done
  );

endinterface

// File: rtl/cnn_window_gen_line_buf.sv
// ---------------------------------------------------------------------------
// cnn_line_buf
// Purpose : DEPTH-deep shift FIFO with enable, built as a RAM with a wrapping
//           pointer. The slot under the pointer is read and overwritten in
//           the same enabled cycle, so dout_o is the din_i value from exactly
//           DEPTH enabled cycles ago.
// Ports   : clk, reset_n (async, active-low; pointer only),
//           en_i (shift enable), din_i (W bits), dout_o (W bits).
// ---------------------------------------------------------------------------
module cnn_line_buf
  import cnn_window_gen_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 28
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  localparam int             PW       = cnt_width(DEPTH);
  localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;

  assign ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
  // Read-before-write: the oldest entry sits under the pointer.
  assign dout_o = mem[ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is never cleared; stale data is masked by the window gating.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// ---------------------------------------------------------------------------
// cnn_window_gen
// Purpose : turns a raster-order pixel stream (all CI channels per beat) into
//           KX x KY x CI windows for a stride-1, no-padding convolution.
//           KY-1 line buffers supply the rows above the live pixel; a window
//           register shifts left one column per accepted beat.
// Ports   : clk, reset_n (async, active-low), i_soft_reset (sync clear,
//           drops a beat in the same cycle), win_if (slave modport: pixel
//           beat in, window / valid / frame_done out, all registered).
// Window  : element (c, ky, kx) at bits [(c*KY*KX + ky*KX + kx)*I_F_BW +: I_F_BW]
// ---------------------------------------------------------------------------
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int CI     = CI_DEF,
  parameter int KX     = KX_DEF,
  parameter int KY     = KY_DEF,
  parameter int I_F_BW = I_F_BW_DEF,
  parameter int IW     = IW_DEF,
  parameter int IH     = IH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_soft_reset,
  cnn_window_gen_if.slave  win_if
);

  localparam int PXW = CI * I_F_BW;
  localparam int FW  = CI * KX * KY * I_F_BW;
  localparam int CW  = cnt_width(IW);
  localparam int RW  = cnt_width(IH);

  localparam logic [CW-1:0] COL_LAST = CW'(IW - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IH - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(KY - 1);

  logic                              accept;
  logic [CW-1:0]                     col_q, col_d;
  logic [RW-1:0]                     row_q, row_d;
  // chain[0] is the live pixel, chain[k+1] is line buffer k (k+1 rows back).
  logic [KY-1:0][PXW-1:0]            chain;
  logic [KY-1:0][KX-1:0][PXW-1:0]    win_q, win_d;
  logic [FW-1:0]                     win_flat;
  logic [FW-1:0]                     fmap_q;
  logic                              win_hit, last_hit;
  logic                              valid_q, done_q;

  // Soft reset wins over a beat in the same cycle: the beat is dropped.
  assign accept   = win_if.i_in_valid & ~i_soft_reset;
  assign chain[0] = win_if.i_in_pixel;

  generate
    for (genvar gi = 0; gi < KY - 1; gi++) begin : g_line
      cnn_line_buf #(
        .W     (PXW),
        .DEPTH (IW)
      ) u_line_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (accept),
        .din_i   (chain[gi]),
        .dout_o  (chain[gi+1])
      );
    end
  endgenerate

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    win_hit  = 1'b0;
    last_hit = 1'b0;
    if (accept) begin
      // A window is complete only once KX columns of this line and KY rows of
      // this frame have arrived; this also hides line-wrap straddles and
      // rows left over from a previous frame.
      win_hit  = (row_q >= ROW_WIN) && (col_q >= COL_WIN);
      last_hit = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX - 1; kx++) begin
          win_d[ky][kx] = win_q[ky][kx+1];
        end
        // Bottom row is the live pixel, rows above come from older lines.
        win_d[ky][KX-1] = chain[KY-1-ky];
      end
    end
  end

  // Reorder [ky][kx][c] storage into the channel-major output layout.
  generate
    for (genvar gc = 0; gc < CI; gc++) begin : g_ch
      for (genvar gy = 0; gy < KY; gy++) begin : g_row
        for (genvar gx = 0; gx < KX; gx++) begin : g_col
          assign win_flat[(gc*KY*KX + gy*KX + gx)*I_F_BW +: I_F_BW] =
                 win_d[gy][gx][gc*I_F_BW +: I_F_BW];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      fmap_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (i_soft_reset) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      fmap_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= win_hit;
      done_q  <= win_hit & last_hit;
      // The output only loads complete windows so it holds the last one
      // across idle cycles and partial-window beats.
      if (win_hit) begin
        fmap_q <= win_flat;
      end
    end
  end

  assign win_if.o_ot_valid      = valid_q;
  assign win_if.o_ot_frame_done = done_q;
  assign win_if.o_ot_fmap       = fmap_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// ---------------------------------------------------------------------------
// tb_cnn_window_gen
// Drives one CI=1 and one CI=2 instance with the same pixel stream (channel 1
// = channel 0 + 50). A frame-image reference model computes every expected
// window directly from pixel coordinates; a small table pins the six windows
// of a 5x4 frame.
// ---------------------------------------------------------------------------
module tb_cnn_window_gen;
  import cnn_window_gen_pkg::*;

  localparam int KX = 3, KY = 3, BW = 8, IW = 5, IH = 4;
  localparam int W1 = 1 * KX * KY * BW;
  localparam int W2 = 2 * KX * KY * BW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic soft_reset = 1'b0;
  always #5 clk = ~clk;

  cnn_window_gen_if #(.CI(1), .KX(KX), .KY(KY), .I_F_BW(BW)) bus1 ();
  cnn_window_gen_if #(.CI(2), .KX(KX), .KY(KY), .I_F_BW(BW)) bus2 ();

  cnn_window_gen #(.CI(1), .KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(soft_reset), .win_if(bus1.slave));
  cnn_window_gen #(.CI(2), .KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(soft_reset), .win_if(bus2.slave));

  typedef struct {
    int beat;   // beat index within the frame that produces the window
    int tl;     // top-left pixel value of the window
    bit done;   // frame_done expected with it
  } vec_t;
  vec_t tbl [6];

  int          checks = 0, failures = 0;
  string       scen = "reset";
  int          n = 0;              // model: beats accepted in current frame
  int          img [IH][IW];
  logic        exp_valid = 1'b0, exp_done = 1'b0;
  logic [W1-1:0] exp_f1 = '0;
  logic [W2-1:0] exp_f2 = '0;
  int          cur_beat = 0;
  logic [W1-1:0] cap_q [$];
  int          capb_q [$];
  bit          capd_q [$];
  bit          have_first2 = 1'b0;
  logic [W2-1:0] first2 = '0;

  task automatic chk(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %0h expected %0h", scen, name, act, exp);
    end
  endtask

  function automatic logic [W2-1:0] model_win(input int r, input int c, input int ci);
    logic [W2-1:0] res = '0;
    for (int ch = 0; ch < ci; ch++)
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX; kx++)
          res[(ch*KY*KX + ky*KX + kx)*BW +: BW] = 8'(img[r-KY+1+ky][c-KX+1+kx] + ch*50);
    return res;
  endfunction

  task automatic model_reset();
    n = 0; exp_valid = 1'b0; exp_done = 1'b0; exp_f1 = '0; exp_f2 = '0;
  endtask

  // One clock: drive, advance the model, sample 1 ns after the edge, compare.
  task automatic step(input bit v, input int val, input bit srst);
    logic [W2-1:0] tmp;
    int r, c;
    bus1.i_in_valid = v;
    bus1.i_in_pixel = 8'(val);
    bus2.i_in_valid = v;
    bus2.i_in_pixel = {8'(val + 50), 8'(val)};
    soft_reset = srst;
    if (srst) begin
      model_reset();
    end else if (v) begin
      r = n / IW;
      c = n % IW;
      img[r][c] = val;
      exp_valid = (r >= KY-1) && (c >= KX-1);
      exp_done  = (r == IH-1) && (c == IW-1);
      if (exp_valid) begin
        exp_f2 = model_win(r, c, 2);
        tmp    = model_win(r, c, 1);
        exp_f1 = tmp[W1-1:0];
      end
      n = (n + 1) % (IW * IH);
    end else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end
    @(posedge clk);
    #1;
    soft_reset = 1'b0;
    chk("valid1", W2'(bus1.o_ot_valid), W2'(exp_valid));
    chk("valid2", W2'(bus2.o_ot_valid), W2'(exp_valid));
    chk("done1",  W2'(bus1.o_ot_frame_done), W2'(exp_done));
    chk("fmap1",  W2'(bus1.o_ot_fmap), W2'(exp_f1));
    chk("fmap2",  bus2.o_ot_fmap, exp_f2);
    if (bus1.o_ot_valid) begin
      cap_q.push_back(bus1.o_ot_fmap);
      capb_q.push_back(cur_beat);
      capd_q.push_back(bus1.o_ot_frame_done);
    end
    if (bus2.o_ot_valid && !have_first2) begin
      have_first2 = 1'b1;
      first2 = bus2.o_ot_fmap;
    end
  endtask

  task automatic frame(input int base, input bit gaps);
    for (int i = 0; i < IW * IH; i++) begin
      if (gaps) while ($urandom_range(0, 1) == 1) step(1'b0, 0, 1'b0);
      cur_beat = i;
      step(1'b1, base + i, 1'b0);
    end
  endtask

  task automatic clear_caps();
    cap_q.delete(); capb_q.delete(); capd_q.delete();
  endtask

  // Compare the captured windows of one frame against the fixed table.
  task automatic check_table(input int base);
    logic [W1-1:0] e;
    chk("win_count", W2'(cap_q.size()), W2'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < cap_q.size()) begin
        e = '0;
        for (int ky = 0; ky < KY; ky++)
          for (int kx = 0; kx < KX; kx++)
            e[(ky*KX + kx)*BW +: BW] = 8'(base + tbl[i].tl + ky*IW + kx);
        chk("tbl_fmap", W2'(cap_q[i]), W2'(e));
        chk("tbl_beat", W2'(capb_q[i]), W2'(tbl[i].beat));
        chk("tbl_done", W2'(capd_q[i]), W2'(tbl[i].done));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9*BW-1:0] ch1_exp;
    tbl[0] = '{12, 0, 1'b0};
    tbl[1] = '{13, 1, 1'b0};
    tbl[2] = '{14, 2, 1'b0};
    tbl[3] = '{17, 5, 1'b0};
    tbl[4] = '{18, 6, 1'b0};
    tbl[5] = '{19, 7, 1'b1};

    bus1.i_in_valid = 1'b0; bus1.i_in_pixel = '0;
    bus2.i_in_valid = 1'b0; bus2.i_in_pixel = '0;

    // Reset state, sampled while reset_n is held low.
    @(posedge clk); #1;
    chk("rst_valid", W2'(bus1.o_ot_valid), '0);
    chk("rst_done",  W2'(bus1.o_ot_frame_done), '0);
    chk("rst_fmap2", bus2.o_ot_fmap, '0);
    reset_n = 1'b1;

    // 1: one full frame, one beat per cycle.
    scen = "s1"; clear_caps(); have_first2 = 1'b0;
    frame(0, 1'b0);
    check_table(0);
    // 6: CI=2 channel 1 of the first window is channel 0 + 50.
    chk("ch1_elem100", W2'(first2[9*BW +: BW]), W2'(50));
    ch1_exp = '0;
    for (int ky = 0; ky < KY; ky++)
      for (int kx = 0; kx < KX; kx++)
        ch1_exp[(ky*KX + kx)*BW +: BW] = 8'(50 + ky*IW + kx);
    chk("ch1_slice", W2'(first2[9*BW +: 9*BW]), W2'(ch1_exp));

    // 2: same frame with random idle gaps.
    scen = "s2"; clear_caps();
    frame(0, 1'b1);
    step(1'b0, 0, 1'b0);
    check_table(0);

    // 3: two back-to-back frames, second offset by 100.
    scen = "s3"; clear_caps();
    frame(0, 1'b0);
    clear_caps();
    frame(100, 1'b0);
    check_table(100);

    // 4: soft reset after pixel 8, coinciding with a beat that must drop.
    scen = "s4";
    for (int i = 0; i < 9; i++) step(1'b1, i, 1'b0);
    step(1'b1, 77, 1'b1);
    clear_caps();
    frame(0, 1'b0);
    check_table(0);

    // 5: async reset between edges while a window is on the output.
    scen = "s5";
    for (int i = 0; i < 13; i++) step(1'b1, i, 1'b0);
    chk("pre_valid", W2'(bus1.o_ot_valid), W2'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", W2'(bus1.o_ot_valid), '0);
    chk("async_done",  W2'(bus1.o_ot_frame_done), '0);
    chk("async_fmap",  W2'(bus1.o_ot_fmap), '0);
    bus1.i_in_valid = 1'b0; bus2.i_in_valid = 1'b0;
    model_reset();
    #3;
    reset_n = 1'b1;
    clear_caps();
    frame(0, 1'b1);
    check_table(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
